// File: rtl/halfband_mac_scheduler_if.sv
// Sample-side handshake and MAC beat bus of the halfband scheduler.
// The scheduler takes the slave view (sample sink, MAC beat source);
// the sample source / MAC consumer takes the master view.
interface halfband_mac_scheduler_if #(
    parameter int SAMPLE_WIDTH = 6,
    parameter int PAIRS        = 15
);
    localparam int CW = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    logic                           valid_in;
    logic signed [SAMPLE_WIDTH-1:0] data_in;
    logic                           ready_in;
    logic                           mac_valid;
    logic                           mac_start;
    logic                           mac_last;
    logic signed [SAMPLE_WIDTH-1:0] mac_a;
    logic signed [SAMPLE_WIDTH-1:0] mac_b;
    logic        [CW-1:0]           mac_coef_idx;
    logic signed [SAMPLE_WIDTH-1:0] mac_center;

    modport master (
        output valid_in, data_in,
        input  ready_in, mac_valid, mac_start, mac_last,
        input  mac_a, mac_b, mac_coef_idx, mac_center
    );

    modport slave (
        input  valid_in, data_in,
        output ready_in, mac_valid, mac_start, mac_last,
        output mac_a, mac_b, mac_coef_idx, mac_center
    );
endinterface

// File: rtl/halfband_mac_scheduler.sv
// Halfband decimator sequencer: keeps the circular sample history, runs the
// input handshake, and every M accepted samples emits one PAIRS-beat
// symmetric-pair sequence (newer/older sample, coefficient index, center tap)
// to the shared MAC. No arithmetic on sample values happens here.
module halfband_mac_scheduler #(
    parameter int SAMPLE_WIDTH = 6,
    parameter int N            = 128,
    parameter int M            = 2,
    parameter int PAIRS        = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    halfband_mac_scheduler_if.slave  bus,
    output logic                     busy
);
    localparam int L   = 4*PAIRS - 1;
    localparam int CTR = 2*PAIRS - 1;
    localparam int AW  = $clog2(N);
    localparam int CW  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
    localparam int FW  = $clog2(L + 1);
    localparam int PW  = (M > 1) ? $clog2(M) : 1;

    localparam logic [CW-1:0] LAST_K     = CW'(PAIRS - 1);
    localparam logic [FW-1:0] FILL_LAST  = FW'(L - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(M - 1);
    localparam logic [AW-1:0] OFS_OLDEST = AW'(L - 1);
    localparam logic [AW-1:0] OFS_CENTER = AW'(CTR);

    // The latched window must survive the writes that arrive while it is read.
    if ((N & (N - 1)) != 0) begin : g_n_pow2
        $error("halfband_mac_scheduler: N must be a power of two");
    end
    if (N < L + 2*M) begin : g_n_depth
        $error("halfband_mac_scheduler: N must be at least L + 2*M");
    end

    typedef enum logic [1:0] {
        S_FILL,
        S_IDLE,
        S_RUN
    } state_t;

    state_t                          state_q, state_d;
    logic        [FW-1:0]            fill_q, fill_d;
    logic        [PW-1:0]            phase_q, phase_d;
    logic                            pending_q, pending_d;
    logic        [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic        [AW-1:0]            trig_q, trig_d;
    logic        [AW-1:0]            base_q, base_d;
    logic        [CW-1:0]            k_q, k_d;
    logic                            vld_q, vld_d;
    logic                            start_q, start_d;
    logic                            last_q, last_d;
    logic signed [SAMPLE_WIDTH-1:0]  a_q, a_d;
    logic signed [SAMPLE_WIDTH-1:0]  b_q, b_d;
    logic signed [SAMPLE_WIDTH-1:0]  c_q, c_d;

    logic signed [SAMPLE_WIDTH-1:0]  mem_q [N];

    logic                            accept;
    logic                            set_pend;
    logic                            clr_pend;
    logic                            issue;
    logic        [AW-1:0]            issue_base;
    logic        [CW-1:0]            issue_k;
    logic        [AW-1:0]            two_k;
    logic        [AW-1:0]            addr_a;
    logic        [AW-1:0]            addr_b;
    logic        [AW-1:0]            addr_c;

    // A second trigger is held off while one is still waiting, so no overrun.
    assign bus.ready_in = !(pending_q && (phase_q == PHASE_LAST));
    assign accept       = bus.valid_in && bus.ready_in;
    assign busy         = (state_q == S_RUN) || pending_q;

    assign bus.mac_valid    = vld_q;
    assign bus.mac_start    = start_q;
    assign bus.mac_last     = last_q;
    assign bus.mac_a        = a_q;
    assign bus.mac_b        = b_q;
    assign bus.mac_center   = c_q;
    assign bus.mac_coef_idx = k_q;

    // History buffer write port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= bus.data_in;
        end
    end

    // Next-state logic: sample counting/triggering plus beat sequencing.
    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        phase_d    = phase_q;
        wr_ptr_d   = wr_ptr_q;
        trig_d     = trig_q;
        base_d     = base_q;
        k_d        = k_q;
        vld_d      = 1'b0;
        start_d    = 1'b0;
        last_d     = 1'b0;
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        set_pend   = 1'b0;
        clr_pend   = 1'b0;
        issue      = 1'b0;
        issue_base = base_q;
        issue_k    = k_q;
        two_k      = '0;
        addr_a     = '0;
        addr_b     = '0;
        addr_c     = '0;

        // Sample side: the L-th sample ends FILL and is phase 0 of the cadence.
        if (accept) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            if (state_q == S_FILL) begin
                if (fill_q == FILL_LAST) begin
                    state_d  = S_IDLE;
                    phase_d  = '0;
                    set_pend = 1'b1;
                end else begin
                    fill_d = fill_q + FW'(1);
                end
            end else if (phase_q == PHASE_LAST) begin
                phase_d  = '0;
                set_pend = 1'b1;
            end else begin
                phase_d = phase_q + PW'(1);
            end
            if (set_pend) begin
                trig_d = wr_ptr_q;
            end
        end

        // Sequencer: a waiting trigger starts right after the last beat.
        case (state_q)
            S_IDLE: begin
                if (pending_q) begin
                    issue      = 1'b1;
                    issue_base = trig_q;
                    issue_k    = '0;
                    clr_pend   = 1'b1;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                if (k_q != LAST_K) begin
                    issue   = 1'b1;
                    issue_k = k_q + CW'(1);
                end else if (pending_q) begin
                    issue      = 1'b1;
                    issue_base = trig_q;
                    issue_k    = '0;
                    clr_pend   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
            end
        endcase

        // Pair addresses walk inward from both ends of the window.
        two_k  = AW'({issue_k, 1'b0});
        addr_a = issue_base - two_k;
        addr_b = issue_base - OFS_OLDEST + two_k;
        addr_c = issue_base - OFS_CENTER;

        if (issue) begin
            base_d  = issue_base;
            k_d     = issue_k;
            vld_d   = 1'b1;
            start_d = (issue_k == '0);
            last_d  = (issue_k == LAST_K);
            a_d     = mem_q[addr_a];
            b_d     = mem_q[addr_b];
            c_d     = mem_q[addr_c];
        end

        pending_d = set_pend ? 1'b1 : (clr_pend ? 1'b0 : pending_q);
    end

    // Control state and registered MAC beat outputs; reset abandons any sequence.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_FILL;
            fill_q    <= '0;
            phase_q   <= '0;
            pending_q <= 1'b0;
            wr_ptr_q  <= '0;
            trig_q    <= '0;
            base_q    <= '0;
            k_q       <= '0;
            vld_q     <= 1'b0;
            start_q   <= 1'b0;
            last_q    <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
        end else begin
            state_q   <= state_d;
            fill_q    <= fill_d;
            phase_q   <= phase_d;
            pending_q <= pending_d;
            wr_ptr_q  <= wr_ptr_d;
            trig_q    <= trig_d;
            base_q    <= base_d;
            k_q       <= k_d;
            vld_q     <= vld_d;
            start_q   <= start_d;
            last_q    <= last_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
        end
    end
endmodule

// File: tb/tb_halfband_mac_scheduler.sv
// Directed bench for halfband_mac_scheduler: fill, decimation cadence,
// backpressure streaming across pointer wrap, reset mid-sequence.
module tb_halfband_mac_scheduler;
    localparam int SW    = 6;
    localparam int N     = 128;
    localparam int M     = 2;
    localparam int PAIRS = 15;
    localparam int L     = 4*PAIRS - 1;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic busy;

    halfband_mac_scheduler_if #(.SAMPLE_WIDTH(SW), .PAIRS(PAIRS)) vif();

    halfband_mac_scheduler #(
        .SAMPLE_WIDTH(SW), .N(N), .M(M), .PAIRS(PAIRS)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    // Reference model state (spec-level behaviour, absolute sample indices)
    logic [SW-1:0] hist[$];
    int  m_cnt   = 0;
    int  m_phase = 0;
    bit  m_pend  = 0;
    int  m_trig  = 0;
    int  m_base  = 0;
    int  m_k     = -1;
    int  rdy_low = 0;
    int  b2b     = 0;
    bit  prev_last = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_cnt = 0; m_phase = 0; m_pend = 0; m_trig = 0; m_base = 0; m_k = -1;
        prev_last = 0;
    endtask

    task automatic model_edge(input bit acc, input logic [SW-1:0] d);
        if (m_k >= 0 && m_k < PAIRS-1) m_k++;
        else if (m_pend) begin
            m_k = 0; m_base = m_trig; m_pend = 0;
        end else m_k = -1;
        if (acc) begin
            hist.push_back(d);
            if (m_cnt == L-1) begin
                m_pend = 1; m_trig = m_cnt; m_phase = 0;
            end else if (m_cnt >= L) begin
                m_phase = (m_phase + 1) % M;
                if (m_phase == 0) begin
                    m_pend = 1; m_trig = m_cnt;
                end
            end
            m_cnt++;
        end
    endtask

    task automatic check_beat();
        chk("mac_valid", vif.mac_valid, (m_k >= 0));
        chk("busy", busy, (m_k >= 0) || m_pend);
        if (m_k >= 0) begin
            chk("mac_start", vif.mac_start, (m_k == 0));
            chk("mac_last", vif.mac_last, (m_k == PAIRS-1));
            chk("mac_coef_idx", 32'(vif.mac_coef_idx), m_k);
            chk("mac_a", 32'($unsigned(vif.mac_a)), 32'(hist[m_base - 2*m_k]));
            chk("mac_b", 32'($unsigned(vif.mac_b)), 32'(hist[m_base - (L-1) + 2*m_k]));
            if (m_k == PAIRS-1)
                chk("mac_center", 32'($unsigned(vif.mac_center)), 32'(hist[m_base - (2*PAIRS-1)]));
        end
        if (prev_last && vif.mac_valid && vif.mac_start) b2b++;
        prev_last = vif.mac_valid && vif.mac_last;
    endtask

    task automatic tick(input logic v, input logic [SW-1:0] d, output bit got);
        logic exp_rdy;
        @(negedge clk);
        vif.valid_in = v;
        vif.data_in  = d;
        exp_rdy = !(m_pend && (m_phase == M-1));
        #1;
        chk("ready_in", vif.ready_in, exp_rdy);
        got = v && vif.ready_in;
        if (v && !vif.ready_in) rdy_low++;
        @(posedge clk);
        model_edge(got, d);
        #1;
        check_beat();
    endtask

    task automatic idle(input int n);
        bit g;
        for (int i = 0; i < n; i++) tick(1'b0, '0, g);
    endtask

    task automatic fill(input int n);
        bit g;
        for (int i = 0; i < n; i++) begin
            tick(1'b1, SW'(i % 32), g);
            chk("fill_accept", g, 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"},  vif.mac_valid, 0);
        chk({tag, "_start"},  vif.mac_start, 0);
        chk({tag, "_last"},   vif.mac_last, 0);
        chk({tag, "_a"},      32'($unsigned(vif.mac_a)), 0);
        chk({tag, "_b"},      32'($unsigned(vif.mac_b)), 0);
        chk({tag, "_center"}, 32'($unsigned(vif.mac_center)), 0);
        chk({tag, "_idx"},    32'(vif.mac_coef_idx), 0);
        chk({tag, "_busy"},   busy, 0);
    endtask

    initial begin
        bit g;
        int tries;
        logic [SW-1:0] d;

        vif.valid_in = 1'b0;
        vif.data_in  = '0;

        // Reset values while reset is held low
        #2 reset = 1'b0;
        #1 check_all_zero("rst_hold");
        @(posedge clk); @(posedge clk); #1;
        check_all_zero("rst_hold_clk");
        @(negedge clk) reset = 1'b1;
        #1 chk("ready_after_reset", vif.ready_in, 1);
        model_reset();

        // Fill and first sequence
        fill(L);
        chk("no_beat_at_trigger_edge", vif.mac_valid, 0);
        idle(1);
        chk("first_b0_a", 32'($unsigned(vif.mac_a)), 26);
        chk("first_b0_b", 32'($unsigned(vif.mac_b)), 0);
        chk("first_b0_idx", 32'(vif.mac_coef_idx), 0);
        chk("first_b0_start", vif.mac_start, 1);
        idle(14);
        chk("first_b14_a", 32'($unsigned(vif.mac_a)), 30);
        chk("first_b14_b", 32'($unsigned(vif.mac_b)), 28);
        chk("first_b14_idx", 32'(vif.mac_coef_idx), 14);
        chk("first_b14_last", vif.mac_last, 1);
        chk("first_b14_center", 32'($unsigned(vif.mac_center)), 29);
        idle(1);
        chk("first_len15", vif.mac_valid, 0);

        // Decimation cadence: sample 59 alone triggers nothing, 60 does
        tick(1'b1, SW'(27), g);
        chk("s59_accepted", g, 1);
        idle(16);
        chk("s59_no_seq", vif.mac_valid, 0);
        tick(1'b1, SW'(28), g);
        chk("s60_accepted", g, 1);
        idle(1);
        chk("s60_b0_a", 32'($unsigned(vif.mac_a)), 28);
        chk("s60_b0_b", 32'($unsigned(vif.mac_b)), 2);
        chk("s60_b0_start", vif.mac_start, 1);
        idle(14);

        // Continuous stream with backpressure, across the wr_ptr wrap
        for (int i = 0; i < 300; i++) begin
            d = SW'(i*7 + 3);
            g = 0;
            tries = 0;
            while (!g && tries < 40) begin
                tick(1'b1, d, g);
                tries++;
            end
            chk("stream_accept_in_time", g, 1);
        end
        chk("ready_dropped", (rdy_low > 0), 1);
        chk("back_to_back_seen", (b2b > 0), 1);
        tries = 0;
        while ((m_k >= 0 || m_pend) && tries < 40) begin
            idle(1);
            tries++;
        end
        chk("drain_idle", busy, 0);

        // Reset during beat 7 of a sequence
        tick(1'b1, SW'(5), g);
        tick(1'b1, SW'(9), g);
        tries = 0;
        while (m_k != 7 && tries < 40) begin
            idle(1);
            tries++;
        end
        chk("reached_beat7", 32'(vif.mac_coef_idx), 7);
        #2 reset = 1'b0;
        #1 check_all_zero("rst_mid_run");
        chk("rst_mid_run_ready", vif.ready_in, 1);
        model_reset();
        @(negedge clk);
        @(negedge clk) reset = 1'b1;
        #1 chk("ready_after_mid_reset", vif.ready_in, 1);
        fill(L);
        idle(1);
        chk("refill_b0_a", 32'($unsigned(vif.mac_a)), 26);
        chk("refill_b0_b", 32'($unsigned(vif.mac_b)), 0);
        chk("refill_b0_start", vif.mac_start, 1);
        idle(15);
        chk("refill_done", vif.mac_valid, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
